// File: rtl/mem_io_bridge_pkg.sv
// Shared parameters and beat layout for the mesh io bridge.
package mem_io_bridge_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int IO_PORTS   = 16;
  localparam int DATA_WIDTH = 16;
  localparam int PORT_WIDTH = clog2(IO_PORTS);
  localparam int DROP_WIDTH = 8;
  localparam int BUS_WIDTH  = IO_PORTS * DATA_WIDTH;

  // tx/rx beats are ordered {port, data} everywhere
  typedef struct packed {
    logic [PORT_WIDTH-1:0] port;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/mem_io_bridge_if.sv
// Mesh io bus plus external tx/rx link as seen by the bridge (master) and its
// surroundings (slave).
interface mem_io_bridge_if;
  import mem_io_bridge_pkg::*;

  logic [IO_PORTS-1:0]   io_active_out;
  logic [BUS_WIDTH-1:0]  io_data_out;
  logic [IO_PORTS-1:0]   io_active_in;
  logic [BUS_WIDTH-1:0]  io_data_in;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [PORT_WIDTH-1:0] tx_port;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [PORT_WIDTH-1:0] rx_port;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [DROP_WIDTH-1:0] drop_count;

  modport master (
    input  io_active_out, io_data_out, tx_ready, rx_valid, rx_port, rx_data,
    output io_active_in, io_data_in, tx_valid, tx_port, tx_data, rx_ready, drop_count
  );

  modport slave (
    output io_active_out, io_data_out, tx_ready, rx_valid, rx_port, rx_data,
    input  io_active_in, io_data_in, tx_valid, tx_port, tx_data, rx_ready, drop_count
  );

endinterface

// File: rtl/mem_io_bridge_arbiter.sv
// Combinational round-robin arbiter: rotate requests so rr_ptr sits at bit 0,
// pick the lowest set bit, then map the offset back to a port index.
module io_rr_arbiter
  import mem_io_bridge_pkg::*;
(
  input  logic [IO_PORTS-1:0]   req,
  input  logic [PORT_WIDTH-1:0] rr_ptr,
  output logic [IO_PORTS-1:0]   grant_oh,
  output logic [PORT_WIDTH-1:0] grant_idx,
  output logic                  any_grant
);

  localparam int SUM_WIDTH = PORT_WIDTH + 1;

  logic [2*IO_PORTS-1:0] doubled;
  logic [2*IO_PORTS-1:0] shifted;
  logic [IO_PORTS-1:0]   rotated;
  logic [PORT_WIDTH-1:0] offset;
  logic [SUM_WIDTH-1:0]  sum;

  // rotate, priority-encode from the pointer upward, un-rotate with wrap
  always_comb begin
    doubled = {req, req};
    shifted = doubled >> rr_ptr;
    rotated = shifted[IO_PORTS-1:0];
    offset  = '0;
    for (int i = IO_PORTS - 1; i >= 0; i--) begin
      if (rotated[i]) offset = PORT_WIDTH'(i);
    end
    sum = SUM_WIDTH'(rr_ptr) + SUM_WIDTH'(offset);
    if (sum >= SUM_WIDTH'(IO_PORTS)) sum = sum - SUM_WIDTH'(IO_PORTS);
    grant_idx = sum[PORT_WIDTH-1:0];
    any_grant = |req;
    grant_oh  = any_grant ? (IO_PORTS'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Bridges the mesh's parallel io bus to a narrow valid/ready link: outbound
// io writes are queued per port and drained round-robin onto tx, inbound rx
// beats become one-cycle io write pulses into the mesh.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mem_io_bridge_if.master bus
);

  localparam int PORT_SPAN  = 1 << PORT_WIDTH;
  localparam int LOSS_WIDTH = clog2(IO_PORTS + 2);
  localparam int SAT_WIDTH  = DROP_WIDTH + 1;
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  logic [IO_PORTS-1:0]   pend;
  logic [DATA_WIDTH-1:0] hold [IO_PORTS];
  logic [PORT_WIDTH-1:0] rr_ptr;
  logic                  tx_valid;
  beat_t                 tx_beat;
  logic [IO_PORTS-1:0]   pulse_active;
  logic [BUS_WIDTH-1:0]  pulse_data;
  logic [DROP_WIDTH-1:0] drop_count;

  logic [IO_PORTS-1:0]   grant_oh;
  logic [PORT_WIDTH-1:0] grant_idx;
  logic                  any_grant;
  logic                  tx_free;
  logic                  grant_fire;
  logic [IO_PORTS-1:0]   granted;
  logic [PORT_WIDTH-1:0] next_ptr;

  logic [PORT_SPAN-1:0]  rx_span;
  logic [IO_PORTS-1:0]   rx_hit;
  logic                  rx_lost;
  logic [BUS_WIDTH-1:0]  rx_vec;

  logic [LOSS_WIDTH-1:0] loss_count;
  logic [SAT_WIDTH-1:0]  drop_sum;
  logic [DROP_WIDTH-1:0] drop_next;

  io_rr_arbiter u_arb (
    .req       (pend),
    .rr_ptr    (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // a grant happens only when the tx register is empty or being emptied
  always_comb begin
    tx_free    = !tx_valid || bus.tx_ready;
    grant_fire = tx_free && any_grant;
    granted    = grant_fire ? grant_oh : '0;
    next_ptr   = (grant_idx == PORT_WIDTH'(IO_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // decode the rx port; a port index beyond the mesh decodes to nothing and is lost
  always_comb begin
    rx_span = PORT_SPAN'(1) << bus.rx_port;
    rx_hit  = bus.rx_valid ? rx_span[IO_PORTS-1:0] : '0;
    rx_lost = bus.rx_valid && !(|rx_span[IO_PORTS-1:0]);
    rx_vec  = '0;
    for (int p = 0; p < IO_PORTS; p++) begin
      if (rx_hit[p]) rx_vec[p*DATA_WIDTH +: DATA_WIDTH] = bus.rx_data;
    end
  end

  // sum every beat lost this cycle; an overwrite on a port being granted is not a loss
  always_comb begin
    loss_count = LOSS_WIDTH'(rx_lost);
    for (int p = 0; p < IO_PORTS; p++) begin
      loss_count = loss_count + LOSS_WIDTH'(bus.io_active_out[p] & pend[p] & ~granted[p]);
    end
    drop_sum  = SAT_WIDTH'(drop_count) + SAT_WIDTH'(loss_count);
    drop_next = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[DROP_WIDTH-1:0];
  end

  // outbound queue, round-robin pointer and tx register; tx reads the old hold value
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      rr_ptr   <= '0;
      tx_valid <= 1'b0;
      tx_beat  <= '0;
      for (int p = 0; p < IO_PORTS; p++) hold[p] <= '0;
    end else begin
      pend <= bus.io_active_out | (pend & ~granted);
      for (int p = 0; p < IO_PORTS; p++) begin
        if (bus.io_active_out[p]) hold[p] <= bus.io_data_out[p*DATA_WIDTH +: DATA_WIDTH];
      end
      if (grant_fire) begin
        tx_valid <= 1'b1;
        tx_beat  <= '{port: grant_idx, data: hold[grant_idx]};
        rr_ptr   <= next_ptr;
      end else if (tx_valid && bus.tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // inbound pulse register: exactly one cycle per accepted rx beat
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_active <= '0;
      pulse_data   <= '0;
    end else begin
      pulse_active <= rx_hit;
      pulse_data   <= rx_vec;
    end
  end

  // saturating loss counter
  always_ff @(posedge clk) begin
    if (rst) drop_count <= '0;
    else     drop_count <= drop_next;
  end

  assign bus.tx_valid     = tx_valid;
  assign bus.tx_port      = tx_beat.port;
  assign bus.tx_data      = tx_beat.data;
  assign bus.rx_ready     = 1'b1;
  assign bus.io_active_in = pulse_active;
  assign bus.io_data_in   = pulse_data;
  assign bus.drop_count   = drop_count;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: outbound queueing/round robin, overwrite
// drops, inbound pulses, drop saturation and mid-operation reset.
module tb_mem_io_bridge;
  import mem_io_bridge_pkg::*;

  localparam int CW = BUS_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_io_bridge_if bus ();

  mem_io_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [CW-1:0] observed,
                             input logic [CW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkTx(input string tag, input logic valid,
                         input logic [PORT_WIDTH-1:0] port, input logic [DATA_WIDTH-1:0] data);
    checkOutput(tag, CW'({bus.tx_valid, bus.tx_port, bus.tx_data}), CW'({valid, port, data}));
  endtask

  task automatic applyStimulus(input logic [IO_PORTS-1:0] active, input logic [CW-1:0] data,
                               input logic ready, input logic rxv,
                               input logic [PORT_WIDTH-1:0] rxp, input logic [DATA_WIDTH-1:0] rxd);
    bus.io_active_out = active;
    bus.io_data_out   = data;
    bus.tx_ready      = ready;
    bus.rx_valid      = rxv;
    bus.rx_port       = rxp;
    bus.rx_data       = rxd;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] slice(input int p, input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] v;
    v = '0;
    v[p*DATA_WIDTH +: DATA_WIDTH] = d;
    return v;
  endfunction

  logic [CW-1:0] all_data;

  initial begin
    $display("[TB] start");
    doReset();

    // reset state
    checkTx("reset_tx", 1'b0, '0, '0);
    checkOutput("reset_active_in", CW'(bus.io_active_in), CW'(0));
    checkOutput("reset_data_in", bus.io_data_in, '0);
    checkOutput("reset_drop", CW'(bus.drop_count), CW'(0));
    checkOutput("reset_rx_ready", CW'(bus.rx_ready), CW'(1));

    // single write on port 3: beat appears two edges after capture, for one cycle
    applyStimulus(16'h0008, slice(3, 16'h1234), 1'b1, 1'b0, '0, '0);
    step();
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
    checkOutput("single_not_yet", CW'(bus.tx_valid), CW'(0));
    step();
    checkTx("single_beat", 1'b1, 4'd3, 16'h1234);
    step();
    checkOutput("single_one_cycle", CW'(bus.tx_valid), CW'(0));
    checkOutput("single_drop", CW'(bus.drop_count), CW'(0));

    // backpressure and round robin over ports 0, 5, 15
    doReset();
    applyStimulus(16'h8021, slice(0, 16'h0A00) | slice(5, 16'h0A05) | slice(15, 16'h0A0F),
                  1'b0, 1'b0, '0, '0);
    step();
    applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
    step();
    checkTx("rr_first", 1'b1, 4'd0, 16'h0A00);
    for (int i = 0; i < 9; i++) begin
      step();
      checkTx("rr_stall_hold", 1'b1, 4'd0, 16'h0A00);
    end
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
    step();
    checkTx("rr_second", 1'b1, 4'd5, 16'h0A05);
    step();
    checkTx("rr_third", 1'b1, 4'd15, 16'h0A0F);
    step();
    checkOutput("rr_drained", CW'(bus.tx_valid), CW'(0));
    checkOutput("rr_ptr_wrap", CW'(dut.rr_ptr), CW'(0));

    // overwrite while pending: older 0xAAAA is lost
    doReset();
    applyStimulus(16'h0002, slice(1, 16'h1111), 1'b0, 1'b0, '0, '0);
    step();
    applyStimulus(16'h0080, slice(7, 16'hAAAA), 1'b0, 1'b0, '0, '0);
    step();
    applyStimulus(16'h0080, slice(7, 16'hBBBB), 1'b0, 1'b0, '0, '0);
    step();
    applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("ovw_drop", CW'(bus.drop_count), CW'(1));
    checkTx("ovw_stalled", 1'b1, 4'd1, 16'h1111);
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
    step();
    checkTx("ovw_beat", 1'b1, 4'd7, 16'hBBBB);
    step();
    checkOutput("ovw_single_beat", CW'(bus.tx_valid), CW'(0));
    checkOutput("ovw_drop_final", CW'(bus.drop_count), CW'(1));

    // capture and grant on the same port in one cycle: old value out, new kept, no drop
    doReset();
    applyStimulus(16'h0004, slice(2, 16'h0001), 1'b1, 1'b0, '0, '0);
    step();
    applyStimulus(16'h0004, slice(2, 16'h0002), 1'b1, 1'b0, '0, '0);
    step();
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
    checkTx("same_old", 1'b1, 4'd2, 16'h0001);
    step();
    checkTx("same_new", 1'b1, 4'd2, 16'h0002);
    checkOutput("same_no_drop", CW'(bus.drop_count), CW'(0));
    step();
    checkOutput("same_drained", CW'(bus.tx_valid), CW'(0));

    // inbound pulses, back to back, including the highest port
    doReset();
    applyStimulus('0, '0, 1'b0, 1'b1, 4'd2, 16'd1);
    step();
    checkOutput("rx1_active", CW'(bus.io_active_in), CW'(16'h0004));
    checkOutput("rx1_data", bus.io_data_in, slice(2, 16'd1));
    applyStimulus('0, '0, 1'b0, 1'b1, 4'd2, 16'd2);
    step();
    checkOutput("rx2_active", CW'(bus.io_active_in), CW'(16'h0004));
    checkOutput("rx2_data", bus.io_data_in, slice(2, 16'd2));
    applyStimulus('0, '0, 1'b0, 1'b1, 4'd9, 16'd3);
    step();
    checkOutput("rx3_active", CW'(bus.io_active_in), CW'(16'h0200));
    checkOutput("rx3_data", bus.io_data_in, slice(9, 16'd3));
    applyStimulus('0, '0, 1'b0, 1'b1, 4'd15, 16'hFFFF);
    step();
    checkOutput("rx15_active", CW'(bus.io_active_in), CW'(16'h8000));
    checkOutput("rx15_data", bus.io_data_in, slice(15, 16'hFFFF));
    applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
    step();
    checkOutput("rx_idle_active", CW'(bus.io_active_in), CW'(0));
    checkOutput("rx_idle_data", bus.io_data_in, '0);
    checkOutput("rx_no_drop", CW'(bus.drop_count), CW'(0));

    // with 16 ports every 4-bit rx_port is valid, so saturation is driven by
    // writing all ports every cycle against a stalled tx
    doReset();
    all_data = '0;
    for (int p = 0; p < IO_PORTS; p++) all_data[p*DATA_WIDTH +: DATA_WIDTH] = 16'hC000 | 16'(p);
    applyStimulus(16'hFFFF, all_data, 1'b0, 1'b0, '0, '0);
    step();
    checkOutput("sat_first_fill", CW'(bus.drop_count), CW'(0));
    step();
    checkOutput("sat_grant_cycle", CW'(bus.drop_count), CW'(15));
    step();
    checkOutput("sat_multi_loss", CW'(bus.drop_count), CW'(31));
    for (int i = 0; i < 14; i++) step();
    checkOutput("sat_reach_max", CW'(bus.drop_count), CW'(255));
    step();
    checkOutput("sat_clamped", CW'(bus.drop_count), CW'(255));
    checkTx("sat_stalled_beat", 1'b1, 4'd0, 16'hC000);

    // reset while a tx beat is stalled withdraws it
    applyStimulus('0, '0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step();
    checkTx("mid_reset_tx", 1'b0, '0, '0);
    checkOutput("mid_reset_active_in", CW'(bus.io_active_in), CW'(0));
    checkOutput("mid_reset_data_in", bus.io_data_in, '0);
    checkOutput("mid_reset_drop", CW'(bus.drop_count), CW'(0));
    checkOutput("mid_reset_rx_ready", CW'(bus.rx_ready), CW'(1));
    rst = 1'b0;
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("post_reset_no_stale", CW'(bus.tx_valid), CW'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
